// File: rtl/weakbus_arbiter.sv
// Two-master round-robin arbiter for the weakcore memory bus; the owner's req/ack handshake passes through combinationally.
// Latency: grant registers one cycle after a request is seen in IDLE; master ack = slave wait states + 1; one IDLE cycle follows every transaction.
// Backpressure: losing or late requesters wait until IDLE. Define WEAKBUS_ARB_TIMEOUT_EN to build the watchdog that completes unacknowledged grants.
module weakbus_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_out,
    output logic [31:0] m0_in,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_out,
    output logic [31:0] m1_in,
    output logic        m1_ack,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_out,
    input  logic [31:0] bus_in,
    input  logic        bus_ack,
    output logic [1:0]  grant,
    input  logic        err_clr,
    output logic        bus_err
);

    // State encoding doubles as the one-hot grant vector.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_GNT0 = 2'b01;
    localparam logic [1:0] ST_GNT1 = 2'b10;

    logic [1:0]  state_q, state_d;
    logic        last_q, last_d;     // owner of the most recent grant: 0 = m0, 1 = m1
    logic        granted;
    logic        own_req, own_wr;
    logic [31:0] own_addr, own_out;
    logic        tmo;                // watchdog completes the grant this cycle
    logic        done;               // grant ends at this edge

    assign granted = (state_q == ST_GNT0) || (state_q == ST_GNT1);

    // Mux the owning master's fields; everything reads zero while idle.
    always_comb begin
        own_req  = 1'b0;
        own_wr   = 1'b0;
        own_addr = 32'h0;
        own_out  = 32'h0;
        case (state_q)
            ST_GNT0: begin
                own_req  = m0_req;
                own_wr   = m0_wr;
                own_addr = m0_addr;
                own_out  = m0_out;
            end
            ST_GNT1: begin
                own_req  = m1_req;
                own_wr   = m1_wr;
                own_addr = m1_addr;
                own_out  = m1_out;
            end
            default: ;
        endcase
    end

`ifdef WEAKBUS_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        bus_err_q, bus_err_d;

    // A real ack in the expiry cycle wins; an already aborted request never times out.
    assign tmo = granted && own_req && !bus_ack && (wd_cnt_q == 16'(TIMEOUT - 1));

    // Count grant cycles without ack; zero whenever the grant ends or the arbiter idles.
    always_comb begin
        wd_cnt_d  = (granted && !done) ? wd_cnt_q + 16'd1 : 16'd0;
        bus_err_d = tmo ? 1'b1 : (err_clr ? 1'b0 : bus_err_q);
    end

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q  <= 16'd0;
            bus_err_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    localparam int unsigned unused_timeout = TIMEOUT;
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign tmo            = 1'b0;
    assign bus_err        = 1'b0;
`endif

    // Dropping req mid-grant is an abort: release the bus without acking.
    assign done = bus_ack || !own_req || tmo;

    // Arbitrate only from IDLE; on a tie the previous owner loses.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_req && (!m1_req || last_q)) begin
                    state_d = ST_GNT0;
                    last_d  = 1'b0;
                end else if (m1_req) begin
                    state_d = ST_GNT1;
                    last_d  = 1'b1;
                end
            end
            default: begin
                // Also recovers the unused 2'b11 encoding, whose own_req reads 0.
                if (done) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Grant state and round-robin pointer; m0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign grant    = state_q;
    assign bus_req  = own_req && !tmo;
    assign bus_wr   = own_wr;
    assign bus_addr = own_addr;
    assign bus_out  = own_out;

    assign m0_ack = (state_q == ST_GNT0) && (bus_ack || tmo);
    assign m1_ack = (state_q == ST_GNT1) && (bus_ack || tmo);
    assign m0_in  = (state_q == ST_GNT0) ? (tmo ? 32'hFFFF_FFFF : bus_in) : 32'h0;
    assign m1_in  = (state_q == ST_GNT1) ? (tmo ? 32'hFFFF_FFFF : bus_in) : 32'h0;

endmodule
